// File: rtl/bidir_bus_ctrl.sv
// Half-duplex controller for a bidirectional pad bus behind tristate buffers.
// Optional write loopback check: define BIDIR_LOOPBACK_CHK_EN.
module bidir_bus_ctrl #(
    parameter int WIDTH      = 8,
    parameter int DRIVE_CYC  = 4,
    parameter int TURN_CYC   = 2,
    parameter int SAMPLE_CYC = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    output logic             rsp_write,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             busy,
    output logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] pad_t,
    input  logic [WIDTH-1:0] pad_o
);

    localparam int MAX_DT = (DRIVE_CYC > TURN_CYC) ? DRIVE_CYC : TURN_CYC;
    localparam int MAXC   = (MAX_DT > SAMPLE_CYC) ? MAX_DT : SAMPLE_CYC;
    localparam int CW     = $clog2(MAXC + 1);

    localparam logic [CW-1:0] DRV_LD = CW'(DRIVE_CYC - 1);
    localparam logic [CW-1:0] TRN_LD = CW'(TURN_CYC - 1);
    localparam logic [CW-1:0] SMP_LD = CW'(SAMPLE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_DRIVE,
        WR_TURN,
        RD_WAIT,
        RESP
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sync_d;
    logic [WIDTH-1:0] sync_q;

    // pad_o is asynchronous; only the second stage is ever consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_d <= '0;
            sync_q <= '0;
        end else begin
            sync_d <= pad_o;
            sync_q <= sync_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pad_t     <= '1;
            pad_i     <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE, RESP: begin
                    if (req_valid) begin
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                        if (req_write) begin
                            pad_i <= req_wdata;
                            pad_t <= '0;
                            cnt   <= DRV_LD;
                            state <= WR_DRIVE;
                        end else begin
                            cnt   <= SMP_LD;
                            state <= RD_WAIT;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WR_DRIVE: begin
                    if (cnt == '0) begin
                        pad_t <= '1;
                        cnt   <= TRN_LD;
                        state <= WR_TURN;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                WR_TURN: begin
                    if (cnt == '0) begin
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b1;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RD_WAIT: begin
                    if (cnt == '0) begin
                        rsp_rdata <= sync_q;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    pad_t     <= '1;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef BIDIR_LOOPBACK_CHK_EN
    // the synchronizer needs two driven cycles before it reflects pad_i
    if (DRIVE_CYC < 3) begin : g_drive_too_short
        $error("bidir_bus_ctrl: loopback check needs DRIVE_CYC >= 3");
    end

    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q   <= 1'b0;
            rsp_err <= 1'b0;
        end else begin
            rsp_err <= 1'b0;
            if (state == WR_DRIVE && cnt == '0) begin
                err_q <= (sync_q != pad_i);
            end
            if (state == WR_TURN && cnt == '0) begin
                rsp_err <= err_q;
            end
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule
